// File: rtl/mont_pkg.sv
// mont_pkg: shared constants for the Montgomery modular exponentiator.
//   - top-level FSM state encodings
//   - operand-select codes for the shared Montgomery multiplier
//   - internal state encodings of the serial multiplier
package mont_pkg;

    // Exponentiator FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_TO_M   = 3'd2;
    localparam logic [2:0] ST_SQ     = 3'd3;
    localparam logic [2:0] ST_MUL    = 3'd4;
    localparam logic [2:0] ST_FROM_M = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Multiplier operand pairs (a, b)
    localparam logic [2:0] SEL_BASE_R2 = 3'd0;  // xm  = MP(base, r2)
    localparam logic [2:0] SEL_ONE_R2  = 3'd1;  // acc = MP(1, r2) = R mod n
    localparam logic [2:0] SEL_ACC_ACC = 3'd2;  // square
    localparam logic [2:0] SEL_ACC_XM  = 3'd3;  // multiply
    localparam logic [2:0] SEL_ACC_ONE = 3'd4;  // leave Montgomery domain

    // Serial multiplier states
    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_ITER = 2'd1;
    localparam logic [1:0] MS_CORR = 2'd2;

endpackage

// File: rtl/mont_mul_serial.sv
// mont_mul_serial: bit-serial radix-2 Montgomery multiplier, p = a*b*R^-1 mod n.
// Takes exactly W+2 cycles: issue (go), W iterations, correction (rdy).
// Ports:
//   clk, rst    clock, synchronous active-high reset (aborts any operation)
//   go          issue request; operands latched when idle
//   a, b, n     operands; requires b < n and n odd
//   rdy         1-cycle pulse in the correction cycle; p is valid then
//   p           product, always < n
module mont_mul_serial
    import mont_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         rdy,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    logic [1:0]   mstate;
    logic [W-1:0] a_sh;
    logic [W-1:0] b_q;
    logic [W-1:0] n_q;
    logic [W+1:0] t;
    logic [W+1:0] t_add;
    logic [W+1:0] t_odd;
    logic [CW-1:0] cnt;

    // One iteration: add a[i]*b, make even by adding n, halve.
    // t stays below 2n, so W+2 bits never overflow.
    always_comb begin
        t_add = t + (a_sh[0] ? {2'b00, b_q} : '0);
        t_odd = t_add[0] ? (t_add + {2'b00, n_q}) : t_add;
    end

    // Final correction is done combinationally in the rdy cycle; the
    // difference is < n so the low W bits are exact.
    always_comb begin
        rdy = (mstate == MS_CORR);
        p   = (t >= {2'b00, n_q}) ? (t[W-1:0] - n_q) : t[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstate <= MS_IDLE;
            a_sh   <= '0;
            b_q    <= '0;
            n_q    <= '0;
            t      <= '0;
            cnt    <= '0;
        end else begin
            case (mstate)
                MS_IDLE: begin
                    if (go) begin
                        a_sh   <= a;
                        b_q    <= b;
                        n_q    <= n;
                        t      <= '0;
                        cnt    <= '0;
                        mstate <= MS_ITER;
                    end
                end
                MS_ITER: begin
                    t    <= t_odd >> 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) mstate <= MS_CORR;
                end
                MS_CORR: mstate <= MS_IDLE;
                default: mstate <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mont_modexp_seq.sv
// mont_modexp_seq: sequential Montgomery modular exponentiation,
// result = base^exp mod n (n odd, n >= 3), MSB-first square-and-multiply
// on one shared serial Montgomery multiplier.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            1-cycle request, sampled only in IDLE
//   base, exp, n, r2 operands (r2 = R^2 mod n, R = 2^W), latched on start
//   busy             high while an operation is in progress
//   done             1-cycle pulse; result/err valid from then on
//   err              n even or n < 3
//   result           base^exp mod n, held until the next completion
// CONST_TIME = 1 multiplies on every exponent bit and discards the product
// when the bit is 0, making latency independent of exp.
module mont_modexp_seq
    import mont_pkg::*;
#(
    parameter int W          = 8,
    parameter int E          = 8,
    parameter int CONST_TIME = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [E-1:0] exp,
    input  logic [W-1:0] n,
    input  logic [W-1:0] r2,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    localparam int CW = (E > 1) ? $clog2(E) : 1;

    logic [2:0]    state;
    logic          phase;      // TO_M: 0 = computing xm, 1 = computing R mod n
    logic          go_q;       // issues the next multiply in the following cycle
    logic [CW-1:0] bitcnt;
    logic [W-1:0]  base_q;
    logic [E-1:0]  exp_q;
    logic [W-1:0]  n_q;
    logic [W-1:0]  r2_q;
    logic [W-1:0]  xm;
    logic [W-1:0]  acc;
    logic [2:0]    sel;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_rdy;
    logic [W-1:0]  mul_p;

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

    always_comb begin
        sel = SEL_ACC_ACC;
        case (state)
            ST_TO_M:   sel = phase ? SEL_ONE_R2 : SEL_BASE_R2;
            ST_MUL:    sel = SEL_ACC_XM;
            ST_FROM_M: sel = SEL_ACC_ONE;
            default:   sel = SEL_ACC_ACC;
        endcase
    end

    always_comb begin
        mul_a = acc;
        mul_b = acc;
        case (sel)
            SEL_BASE_R2: begin mul_a = base_q;  mul_b = r2_q;   end
            SEL_ONE_R2:  begin mul_a = W'(1);   mul_b = r2_q;   end
            SEL_ACC_XM:  begin mul_a = acc;     mul_b = xm;     end
            SEL_ACC_ONE: begin mul_a = acc;     mul_b = W'(1);  end
            default:     begin mul_a = acc;     mul_b = acc;    end
        endcase
    end

    mont_mul_serial #(.W(W)) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (go_q),
        .a   (mul_a),
        .b   (mul_b),
        .n   (n_q),
        .rdy (mul_rdy),
        .p   (mul_p)
    );

    // Each multiply result is captured in its rdy cycle and the next one is
    // issued the very next cycle, so every operation costs exactly W+2 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            phase  <= 1'b0;
            go_q   <= 1'b0;
            bitcnt <= '0;
            base_q <= '0;
            exp_q  <= '0;
            n_q    <= '0;
            r2_q   <= '0;
            xm     <= '0;
            acc    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            go_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        n_q    <= n;
                        r2_q   <= r2;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!n_q[0] || (n_q < W'(3))) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= ST_DONE;
                    end else begin
                        phase <= 1'b0;
                        go_q  <= 1'b1;
                        state <= ST_TO_M;
                    end
                end
                ST_TO_M: begin
                    if (mul_rdy) begin
                        go_q <= 1'b1;
                        if (!phase) begin
                            xm    <= mul_p;
                            phase <= 1'b1;
                        end else begin
                            acc    <= mul_p;
                            bitcnt <= CW'(E - 1);
                            state  <= ST_SQ;
                        end
                    end
                end
                ST_SQ: begin
                    if (mul_rdy) begin
                        acc  <= mul_p;
                        go_q <= 1'b1;
                        if (exp_q[bitcnt] || (CONST_TIME != 0)) state <= ST_MUL;
                        else if (bitcnt == '0)                  state <= ST_FROM_M;
                        else                                    bitcnt <= bitcnt - CW'(1);
                    end
                end
                ST_MUL: begin
                    if (mul_rdy) begin
                        if (exp_q[bitcnt]) acc <= mul_p;
                        go_q <= 1'b1;
                        if (bitcnt == '0) begin
                            state <= ST_FROM_M;
                        end else begin
                            bitcnt <= bitcnt - CW'(1);
                            state  <= ST_SQ;
                        end
                    end
                end
                ST_FROM_M: begin
                    if (mul_rdy) begin
                        result <= mul_p;
                        err    <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
